// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin one-hot arbiter.
//   arb_state_e    : arbiter FSM state (IDLE / GRANTED)
//   arb_vec_t      : request/grant vector sized for the largest legal INPUTS
//   rotr / rotl    : rotate the low n bits of a vector right / left by sh
//   onehot_to_idx  : binary index of the set bit of a one-hot vector
// Vectors narrower than ARB_MAX_INPUTS are passed zero-extended; bits at or
// above n are ignored on input and returned as zero.
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int unsigned ARB_MAX_INPUTS = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    typedef logic [ARB_MAX_INPUTS-1:0] arb_vec_t;

    // Bit i of the result is bit (i+sh) mod n of the source.
    function automatic arb_vec_t rotr(input arb_vec_t v,
                                      input int unsigned sh,
                                      input int unsigned n);
        arb_vec_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < ARB_MAX_INPUTS; i++) begin
            if (i < n) begin
                j = (i + sh) % n;
                r[i[4:0]] = v[j[4:0]];
            end
        end
        return r;
    endfunction

    // Inverse of rotr: bit i of the source lands at (i+sh) mod n.
    function automatic arb_vec_t rotl(input arb_vec_t v,
                                      input int unsigned sh,
                                      input int unsigned n);
        arb_vec_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < ARB_MAX_INPUTS; i++) begin
            if (i < n) begin
                j = (i + sh) % n;
                r[j[4:0]] = v[i[4:0]];
            end
        end
        return r;
    endfunction

    // OR of the indices of all set bits; exact for one-hot, 0 for all-zero.
    function automatic logic [4:0] onehot_to_idx(input arb_vec_t v);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < ARB_MAX_INPUTS; i++) begin
            if (v[i[4:0]]) begin
                idx = idx | i[4:0];
            end
        end
        return idx;
    endfunction

endpackage : arb_pkg

// File: rtl/rr_pick_first.sv
// -----------------------------------------------------------------------------
// rr_pick_first
// Combinational round-robin picker: returns the first set bit of i_req when
// scanning from index i_ptr upward, wrapping modulo INPUTS.
// Ports:
//   i_req  [INPUTS-1:0]  candidate request vector
//   i_ptr  [PTRW-1:0]    index searched first (0..INPUTS-1)
//   o_pick [INPUTS-1:0]  one-hot pick, zero when i_req is zero
//   o_any                at least one request present
// -----------------------------------------------------------------------------
module rr_pick_first
    import arb_pkg::*;
#(
    parameter int unsigned INPUTS = 3,
    parameter int unsigned PTRW   = 2
) (
    input  logic [INPUTS-1:0] i_req,
    input  logic [PTRW-1:0]   i_ptr,
    output logic [INPUTS-1:0] o_pick,
    output logic              o_any
);

    logic [INPUTS-1:0] w_rot;
    logic [INPUTS-1:0] w_first;

    // Rotating right by ptr puts the highest-priority requester at bit 0, so
    // a plain lowest-set-bit isolate finds the round-robin winner.
    assign w_rot   = INPUTS'(rotr(arb_vec_t'(i_req), 32'(i_ptr), INPUTS));
    assign w_first = w_rot & (~w_rot + INPUTS'(1));
    assign o_pick  = INPUTS'(rotl(arb_vec_t'(w_first), 32'(i_ptr), INPUTS));
    assign o_any   = |i_req;

endmodule : rr_pick_first

// File: rtl/rr_arbiter_1hot.sv
// -----------------------------------------------------------------------------
// rr_arbiter_1hot
// Round-robin arbiter producing a registered one-hot select for a Mux1hot.
// A grant is held until ack; priority then moves past the served input.
// Dropping the granted request without ack aborts the grant (ptr unchanged).
// Ports:
//   clk          clock, all state updates on posedge
//   reset        asynchronous active-low reset
//   req          [INPUTS-1:0] per-input request levels
//   ack          consumer accepted the granted input this cycle
//   grant        [INPUTS-1:0] registered one-hot grant or zero (Mux1hot.sel)
//   grant_valid  registered, equals |grant
//   grant_idx    [IDXW-1:0] registered binary index of grant, 0 when idle
// WIDTH is the paired mux data width and is carried only for symmetry.
// -----------------------------------------------------------------------------
module rr_arbiter_1hot
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned INPUTS = 3,
    parameter int unsigned IDXW   = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INPUTS-1:0] req,
    input  logic              ack,
    output logic [INPUTS-1:0] grant,
    output logic              grant_valid,
    output logic [IDXW-1:0]   grant_idx
);

    if (WIDTH == 0 || INPUTS == 0 || INPUTS > ARB_MAX_INPUTS) begin : g_param_check
        $error("rr_arbiter_1hot: WIDTH must be >= 1 and INPUTS in 1..32");
    end

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(INPUTS - 1);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [INPUTS-1:0] r_grant;
    logic [INPUTS-1:0] w_grant_nxt;
    logic [IDXW-1:0]   r_ptr;
    logic [IDXW-1:0]   w_ptr_nxt;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   w_idx_nxt;
    logic              r_valid;

    logic [IDXW-1:0]   w_ptr_adv;
    logic [INPUTS-1:0] w_req_others;
    logic              w_granted_req;
    logic [INPUTS-1:0] w_pick_idle;
    logic              w_any_idle;
    logic [INPUTS-1:0] w_pick_next;
    logic              w_any_next;

    // Pointer value after serving the current grant.
    assign w_ptr_adv     = (r_idx == LAST_IDX) ? '0 : r_idx + IDXW'(1);
    assign w_req_others  = req & ~r_grant;
    assign w_granted_req = |(req & r_grant);

    // Fresh arbitration from IDLE uses the stored pointer.
    rr_pick_first #(
        .INPUTS (INPUTS),
        .PTRW   (IDXW)
    ) u_pick_idle (
        .i_req  (req),
        .i_ptr  (r_ptr),
        .o_pick (w_pick_idle),
        .o_any  (w_any_idle)
    );

    // Back-to-back re-pick on ack: served bit masked, pointer already advanced,
    // so the next grant is available the very next cycle.
    rr_pick_first #(
        .INPUTS (INPUTS),
        .PTRW   (IDXW)
    ) u_pick_next (
        .i_req  (w_req_others),
        .i_ptr  (w_ptr_adv),
        .o_pick (w_pick_next),
        .o_any  (w_any_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= |w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_any_idle) begin
                    w_state_nxt = GRANTED;
                    w_grant_nxt = w_pick_idle;
                end
            end
            GRANTED: begin
                if (ack) begin
                    // Ack wins even if the granted request dropped this cycle.
                    w_ptr_nxt = w_ptr_adv;
                    if (w_any_next) begin
                        w_grant_nxt = w_pick_next;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end
                end else if (!w_granted_req) begin
                    // Abort: pointer is left alone, re-arbitrate from IDLE.
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
        w_idx_nxt = IDXW'(onehot_to_idx(arb_vec_t'(w_grant_nxt)));
    end

    always_comb begin
        grant       = r_grant;
        grant_valid = r_valid;
        grant_idx   = r_idx;
    end

endmodule : rr_arbiter_1hot

// File: tb/tb_rr_arbiter_1hot.sv
module tb_rr_arbiter_1hot;

    localparam int N = 3;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic       ack;
    logic [2:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_arbiter_1hot #(
        .WIDTH  (3),
        .INPUTS (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    typedef struct {
        logic [2:0] g;
        logic       v;
        logic [1:0] idx;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_ptr;
    int m_idx;
    bit m_valid;

    logic [8:0] mux_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int p);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [2:0] mux1hot(input logic [2:0] sel, input logic [8:0] din);
        logic [2:0] o;
        o = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) o = o | din[3*i +: 3];
        end
        return o;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_idx   = 0;
        m_valid = 0;
        sb.delete();
    endtask

    task automatic step(input string tag, input logic [2:0] r, input logic a);
        exp_t       e;
        logic [2:0] masked;
        int         p;
        req = r;
        ack = a;
        if (!m_valid) begin
            p = pick(r, m_ptr);
            if (p >= 0) begin
                m_valid = 1;
                m_idx   = p;
            end
        end else if (a) begin
            m_ptr  = (m_idx + 1) % N;
            masked = r;
            masked[m_idx] = 1'b0;
            p = pick(masked, m_ptr);
            if (p >= 0) begin
                m_idx = p;
            end else begin
                m_valid = 0;
                m_idx   = 0;
            end
        end else if (!r[m_idx]) begin
            m_valid = 0;
            m_idx   = 0;
        end
        e.v   = m_valid;
        e.g   = m_valid ? 3'(1 << m_idx) : 3'b000;
        e.idx = m_valid ? 2'(m_idx) : 2'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ".grant"}, 32'(grant), 32'(e.g));
            check({tag, ".valid"}, 32'(grant_valid), 32'(e.v));
            check({tag, ".idx"}, 32'(grant_idx), 32'(e.idx));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'd0);
        check({tag, ".valid"}, 32'(grant_valid), 32'd0);
        check({tag, ".idx"}, 32'(grant_idx), 32'd0);
    endtask

    initial begin
        logic [2:0] rr;
        logic       ra;
        logic [2:0] prev_g;
        int         scnt[N];
        int         gi;
        logic [2:0] exp_mux[4];

        mux_in = 9'b011_010_001;
        exp_mux[0] = 3'd1; exp_mux[1] = 3'd2; exp_mux[2] = 3'd3; exp_mux[3] = 3'd1;

        // Reset with requests pending
        reset = 1'b0;
        req   = 3'b111;
        ack   = 1'b0;
        model_reset();
        #2;
        check_idle("rst");
        @(posedge clk);
        #1;
        check_idle("rst_hold");
        reset = 1'b1;
        step("first", 3'b111, 1'b0);
        check("first.grant_const", 32'(grant), 32'b001);

        // Reset mid-grant acts without a clock edge
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_idle("midrst");
        #1;
        reset = 1'b1;

        // Rotation with ack every cycle, paired mux output
        step("rot0", 3'b111, 1'b0);
        check("rot0.mux", 32'(mux1hot(grant, mux_in)), 32'(exp_mux[0]));
        step("rot1", 3'b111, 1'b1);
        check("rot1.mux", 32'(mux1hot(grant, mux_in)), 32'(exp_mux[1]));
        step("rot2", 3'b111, 1'b1);
        check("rot2.mux", 32'(mux1hot(grant, mux_in)), 32'(exp_mux[2]));
        step("rot3", 3'b111, 1'b1);
        check("rot3.mux", 32'(mux1hot(grant, mux_in)), 32'(exp_mux[3]));

        // Hold: grant 010 survives new requests while ack is low
        step("hold_get", 3'b111, 1'b1);
        check("hold_get.const", 32'(grant), 32'b010);
        step("hold0", 3'b010, 1'b0);
        for (int i = 0; i < 4; i++) step("hold", 3'b111, 1'b0);
        check("hold.const", 32'(grant), 32'b010);
        step("hold_ack", 3'b111, 1'b1);
        check("hold_ack.const", 32'(grant), 32'b100);

        // Abort: drop req[0] while granted, pointer must stay at 0
        step("ab_get", 3'b111, 1'b1);
        check("ab_get.const", 32'(grant), 32'b001);
        step("abort", 3'b110, 1'b0);
        check("abort.const", 32'(grant), 32'b000);
        step("ab_regrant", 3'b001, 1'b0);
        step("abort2", 3'b000, 1'b0);
        step("ab_ptr0", 3'b111, 1'b0);
        check("ab_ptr0.const", 32'(grant), 32'b001);

        // Last served with no others, then wrap
        step("last_get", 3'b100, 1'b1);
        check("last_get.const", 32'(grant), 32'b100);
        step("last_ack", 3'b100, 1'b1);
        check("last_ack.const", 32'(grant), 32'b000);
        step("wrap", 3'b101, 1'b0);
        check("wrap.const", 32'(grant), 32'b001);

        // Ack with dropped request advances; ack in IDLE is ignored
        step("ackdrop", 3'b000, 1'b1);
        step("idle_ack", 3'b000, 1'b1);
        step("after_idle_ack", 3'b111, 1'b0);
        check("after_idle_ack.const", 32'(grant), 32'b010);

        // Random traffic with invariant and starvation checks
        for (int i = 0; i < N; i++) scnt[i] = 0;
        rr = req;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) rr[i] = ~rr[i];
            end
            ra = ($urandom_range(0, 2) == 0);
            prev_g = grant;
            step("rand", rr, ra);
            check("rand.onehot0", 32'($onehot0(grant)), 32'd1);
            gi = 0;
            for (int i = 0; i < N; i++) if (grant[i]) gi = i;
            check("rand.idx_match", 32'(grant_idx), 32'(gi));
            for (int i = 0; i < N; i++) begin
                if (!rr[i] || prev_g[i]) scnt[i] = 0;
                else if (ra && prev_g != 3'b000) scnt[i]++;
                check("rand.starve", 32'(scnt[i] <= N), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rr_arbiter_1hot
